sipo_frame_rx: RTL and testbench

Serial-to-parallel frame receiver that sits directly downstream of the serial shift chain and consumes its one-bit-per-clock output stream.
- Frame format: start bit (0), WIDTH data bits, optional even-parity bit, stop bit (1).
- Delivers each frame as a parallel word on a valid/ready interface, with parity, framing and overrun status.

---
 rtl/serial_pkg.sv | 22 ++
 rtl/serial_bit_ctr.sv | 37 +++
 rtl/sipo_frame_rx.sv | 141 ++++++++++++++
 tb/tb_sipo_frame_rx.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_pkg
// Description : Frame-format constants and receiver state encoding shared by
//               both ends of the serial link.
// Revision    : 1.0  initial release
// ============================================================================
package serial_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      DATA      = 3'd1,
      PARITY    = 3'd2,
      STOP      = 3'd3,
      WAIT_IDLE = 3'd4
   } state_t;

   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;

endpackage
`default_nettype wire

// File: rtl/serial_bit_ctr.sv
`default_nettype none
// ============================================================================
// Module      : serial_bit_ctr
// Description : Data-bit counter with clear, enable and terminal-count flag.
// Revision    : 1.0  initial release
// ============================================================================
module serial_bit_ctr #(
   parameter int WIDTH = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);

   localparam int            CW     = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Flags that the next enabled count reaches WIDTH; kept independent of
   // i_en so the controlling FSM has no combinational loop through it.
   assign o_tc = (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/sipo_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : sipo_frame_rx
// Description : Serial frame receiver (start, data, optional even parity,
//               stop) delivering words on a valid/ready holding register.
// Revision    : 1.0  initial release
// ============================================================================
module sipo_frame_rx #(
   parameter int WIDTH     = 8,
   parameter bit PARITY_EN = 1'b1,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin,
   output logic [WIDTH-1:0] pout,
   output logic             pvalid,
   input  logic             pready,
   output logic             perr,
   output logic             ferr,
   output logic             ovr,
   output logic             busy
);

   import serial_pkg::*;

   state_t           r_state;
   state_t           w_next;
   logic             w_shift_en;
   logic             w_ctr_clr;
   logic             w_par_cap;
   logic             w_stop;
   logic             w_tc;
   logic             w_consume;
   logic             w_load;
   logic             w_perr;
   logic [WIDTH-1:0] w_shift_nx;
   logic [WIDTH-1:0] r_shift;
   logic             r_par;
   logic [WIDTH-1:0] r_pout;
   logic             r_pvalid;
   logic             r_perr;
   logic             r_ferr;
   logic             r_ovr;

   serial_bit_ctr #(.WIDTH(WIDTH)) u_bit_ctr (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_ctr_clr),
      .i_en  (w_shift_en),
      .o_tc  (w_tc)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next     = r_state;
      w_shift_en = 1'b0;
      w_ctr_clr  = 1'b0;
      w_par_cap  = 1'b0;
      w_stop     = 1'b0;
      case (r_state)
         IDLE: begin
            w_ctr_clr = 1'b1;
            if (sin == START_LEVEL) w_next = DATA;
         end
         DATA: begin
            w_shift_en = 1'b1;
            if (w_tc) w_next = PARITY_EN ? PARITY : STOP;
         end
         PARITY: begin
            w_par_cap = 1'b1;
            w_next    = STOP;
         end
         STOP: begin
            w_stop = 1'b1;
            w_next = (sin == IDLE_LEVEL) ? IDLE : WAIT_IDLE;
         end
         WAIT_IDLE: begin
            if (sin == IDLE_LEVEL) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   if (MSB_FIRST) begin : g_msb_first
      assign w_shift_nx = {r_shift[WIDTH-2:0], sin};
   end else begin : g_lsb_first
      assign w_shift_nx = {sin, r_shift[WIDTH-1:1]};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_shift <= '0;
         r_par   <= 1'b0;
      end else begin
         if (w_shift_en) r_shift <= w_shift_nx;
         if (w_par_cap)  r_par   <= sin;
      end
   end

   // A full holding register still accepts a new word if it drains this edge.
   assign w_consume = r_pvalid & pready;
   assign w_load    = w_stop & (~r_pvalid | w_consume);
   assign w_perr    = PARITY_EN ? ((^r_shift) ^ r_par) : 1'b0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pout   <= '0;
         r_pvalid <= 1'b0;
         r_perr   <= 1'b0;
         r_ferr   <= 1'b0;
         r_ovr    <= 1'b0;
      end else begin
         r_ovr <= w_stop & ~w_load;
         if (w_load) begin
            r_pout   <= r_shift;
            r_pvalid <= 1'b1;
            r_perr   <= w_perr;
            r_ferr   <= (sin != IDLE_LEVEL);
         end else if (w_consume) begin
            r_pvalid <= 1'b0;
         end
      end
   end

   assign pout   = r_pout;
   assign pvalid = r_pvalid;
   assign perr   = r_perr;
   assign ferr   = r_ferr;
   assign ovr    = r_ovr;
   assign busy   = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sipo_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_sipo_frame_rx
// Description : Self-checking bench for sipo_frame_rx: two configurations
//               share one serial line, checked against a frame-level model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sipo_frame_rx;

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b0;
   logic       sin    = 1'b1;
   logic       pready = 1'b0;
   logic [7:0] pout0, pout1;
   logic       pvalid0, perr0, ferr0, ovr0, busy0;
   logic       pvalid1, perr1, ferr1, ovr1, busy1;

   always #5 clk = ~clk;

   sipo_frame_rx #(.WIDTH(8), .PARITY_EN(1'b1), .MSB_FIRST(1'b0)) dut0 (
      .clk(clk), .rst(rst_n), .sin(sin), .pout(pout0), .pvalid(pvalid0),
      .pready(pready), .perr(perr0), .ferr(ferr0), .ovr(ovr0), .busy(busy0)
   );

   sipo_frame_rx #(.WIDTH(8), .PARITY_EN(1'b0), .MSB_FIRST(1'b1)) dut1 (
      .clk(clk), .rst(rst_n), .sin(sin), .pout(pout1), .pvalid(pvalid1),
      .pready(pready), .perr(perr1), .ferr(ferr1), .ovr(ovr1), .busy(busy1)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame-level model: collect the bits after a start bit, decode once the
   // whole frame (data, parity, stop) is in, then apply holding-register rules.
   int         m_mode [2];   // 0 hunting, 1 in frame, 2 waiting for a 1
   int         m_cnt  [2];
   logic       m_bits [2][16];
   logic [7:0] e_pout [2];
   logic       e_pvalid [2], e_perr [2], e_ferr [2], e_ovr [2], e_busy [2];

   task automatic model_step(input int k, input logic s, input logic rdy, input logic rn);
      int         pe;
      bit         msb;
      logic       consumed, loaded, stopb, parb;
      logic [7:0] d;
      pe  = (k == 0) ? 1 : 0;
      msb = (k == 1);
      if (!rn) begin
         m_mode[k] = 0; m_cnt[k] = 0;
         e_pout[k] = 8'h00; e_pvalid[k] = 1'b0; e_perr[k] = 1'b0;
         e_ferr[k] = 1'b0; e_ovr[k] = 1'b0; e_busy[k] = 1'b0;
         return;
      end
      consumed  = e_pvalid[k] && rdy;
      loaded    = 1'b0;
      e_ovr[k]  = 1'b0;
      if (m_mode[k] == 0) begin
         if (s == 1'b0) begin
            m_mode[k] = 1;
            m_cnt[k]  = 0;
         end
      end else if (m_mode[k] == 1) begin
         m_bits[k][m_cnt[k]] = s;
         m_cnt[k]++;
         if (m_cnt[k] == 8 + pe + 1) begin
            d = 8'h00;
            for (int i = 0; i < 8; i++) d[msb ? 7 - i : i] = m_bits[k][i];
            parb  = (pe != 0) ? m_bits[k][8] : 1'b0;
            stopb = m_bits[k][8 + pe];
            if (!e_pvalid[k] || consumed) begin
               e_pout[k]   = d;
               e_perr[k]   = (pe != 0) ? ((^d) ^ parb) : 1'b0;
               e_ferr[k]   = ~stopb;
               e_pvalid[k] = 1'b1;
               loaded      = 1'b1;
            end else begin
               e_ovr[k] = 1'b1;
            end
            m_mode[k] = stopb ? 0 : 2;
         end
      end else begin
         if (s == 1'b1) m_mode[k] = 0;
      end
      if (consumed && !loaded) e_pvalid[k] = 1'b0;
      e_busy[k] = (m_mode[k] != 0);
   endtask

   always @(posedge clk) begin
      model_step(0, sin, pready, rst_n);
      model_step(1, sin, pready, rst_n);
      #1;
      check("pvalid0", pvalid0, e_pvalid[0]);
      check("pout0",   pout0,   e_pout[0]);
      check("perr0",   perr0,   e_perr[0]);
      check("ferr0",   ferr0,   e_ferr[0]);
      check("ovr0",    ovr0,    e_ovr[0]);
      check("busy0",   busy0,   e_busy[0]);
      check("pvalid1", pvalid1, e_pvalid[1]);
      check("pout1",   pout1,   e_pout[1]);
      check("perr1",   perr1,   e_perr[1]);
      check("ferr1",   ferr1,   e_ferr[1]);
      check("ovr1",    ovr1,    e_ovr[1]);
      check("busy1",   busy1,   e_busy[1]);
   end

   bit rand_rdy = 1'b0;

   task automatic send_bit(input logic b);
      @(negedge clk);
      sin = b;
      if (rand_rdy) pready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic after_edge();
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) send_bit(1'b1);
   endtask

   task automatic send_head(input logic [7:0] d, input bit pe, input bit msb, input bit par_flip);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(msb ? d[7 - i] : d[i]);
      if (pe) send_bit((^d) ^ par_flip);
   endtask

   task automatic send_frame(input logic [7:0] d, input bit pe, input bit msb,
                             input bit par_flip, input logic stopb);
      send_head(d, pe, msb, par_flip);
      send_bit(stopb);
   endtask

   initial begin
      #1_000_000;
      n_fail++;
      $display("FAIL watchdog: simulation did not finish, failures=%0d", n_fail);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      repeat (2) @(posedge clk);
      #2;
      check("rst_pvalid0", pvalid0, 1'b0);
      check("rst_pout0",   pout0,   8'h00);
      check("rst_busy0",   busy0,   1'b0);
      check("rst_ovr1",    ovr1,    1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      pready = 1'b1;
      idle(3);

      // Frame 0xA5, good parity, consumed immediately: one-cycle pvalid.
      send_head(8'hA5, 1'b1, 1'b0, 1'b0);
      after_edge();
      check("t1_pvalid_before_stop", pvalid0, 1'b0);
      send_bit(1'b1);
      after_edge();
      check("t1_pvalid", pvalid0, 1'b1);
      check("t1_pout",   pout0,   8'hA5);
      check("t1_perr",   perr0,   1'b0);
      check("t1_ferr",   ferr0,   1'b0);
      check("t1_model_pout", e_pout[0], 8'hA5);
      after_edge();
      check("t1_pvalid_drop", pvalid0, 1'b0);

      // Bad parity, then a framing error followed by a held-low line.
      send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1);
      after_edge();
      check("t2_pout", pout0, 8'hA5);
      check("t2_perr", perr0, 1'b1);
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
      after_edge();
      check("t2_ferr", ferr0, 1'b1);
      check("t2_pout3c", pout0, 8'h3C);
      check("t2_busy_stop", busy0, 1'b1);
      send_bit(1'b0);
      after_edge();
      check("t2_busy_wait1", busy0, 1'b1);
      send_bit(1'b0);
      after_edge();
      check("t2_busy_wait2", busy0, 1'b1);
      send_bit(1'b1);
      after_edge();
      check("t2_busy_idle", busy0, 1'b0);

      // Overrun: second back-to-back frame dropped while the first is held.
      idle(12);
      pready = 1'b0;
      send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b1);
      send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b1);
      after_edge();
      check("t3_ovr",    ovr0,    1'b1);
      check("t3_pout",   pout0,   8'h11);
      check("t3_pvalid", pvalid0, 1'b1);
      check("t3_model_ovr", e_ovr[0], 1'b1);
      after_edge();
      check("t3_ovr_pulse", ovr0, 1'b0);
      @(negedge clk);
      pready = 1'b1;
      after_edge();
      check("t3_consumed", pvalid0, 1'b0);

      // Consume and load on the same edge.
      pready = 1'b0;
      idle(12);
      send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b1);
      idle(2);
      check("t4_held", pout0, 8'h11);
      send_head(8'h22, 1'b1, 1'b0, 1'b0);
      send_bit(1'b1);
      pready = 1'b1;
      after_edge();
      check("t4_pout",   pout0,   8'h22);
      check("t4_pvalid", pvalid0, 1'b1);
      check("t4_ovr",    ovr0,    1'b0);
      after_edge();
      check("t4_drain", pvalid0, 1'b0);

      // Asynchronous reset in the middle of a frame.
      pready = 1'b0;
      idle(12);
      send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b1);
      idle(2);
      check("t5_held", pvalid0, 1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b1);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("t5_pvalid0", pvalid0, 1'b0);
      check("t5_pout0",   pout0,   8'h00);
      check("t5_busy0",   busy0,   1'b0);
      check("t5_busy1",   busy1,   1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle(8);
      check("t5_no_delivery", pvalid0, 1'b0);
      check("t5_idle",        busy0,   1'b0);
      pready = 1'b1;
      send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b1);
      after_edge();
      check("t5_pout",   pout0,   8'h5A);
      check("t5_pvalid", pvalid0, 1'b1);
      check("t5_perr",   perr0,   1'b0);

      // MSB-first, no parity configuration.
      idle(12);
      send_head(8'h81, 1'b0, 1'b1, 1'b0);
      after_edge();
      check("t6_pvalid_before_stop", pvalid1, 1'b0);
      send_bit(1'b1);
      after_edge();
      check("t6_pout",   pout1,   8'h81);
      check("t6_pvalid", pvalid1, 1'b1);
      check("t6_perr",   perr1,   1'b0);
      check("t6_model_pout", e_pout[1], 8'h81);

      // Randomized traffic for both frame formats plus line noise.
      rand_rdy = 1'b1;
      for (int it = 0; it < 200; it++) begin
         n = $urandom_range(0, 5);
         if (n <= 1) begin
            send_frame(8'($urandom), 1'b1, 1'b0, ($urandom_range(0, 7) == 0),
                       ($urandom_range(0, 7) != 0));
         end else if (n <= 3) begin
            send_frame(8'($urandom), 1'b0, 1'b1, 1'b0, ($urandom_range(0, 7) != 0));
         end else begin
            n = $urandom_range(1, 6);
            for (int j = 0; j < n; j++) send_bit(1'($urandom_range(0, 1)));
         end
         idle($urandom_range(0, 2));
      end
      rand_rdy = 1'b0;
      pready = 1'b1;
      idle(20);
      after_edge();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
